wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the register file and drives its write port (wen, rd, dIn).
- Accepts retiring instructions from the memory stage: either an ALU result or a load.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the data.
- Issues exactly one registered write pulse per instruction and back-pressures upstream while a load is outstanding.

Parameters:
XLEN, 32, datapath width; the register-file data width.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rstn  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  stage can accept; equals (state==IDLE).
in_rd  in  REG_AW  destination register.
in_result  in  XLEN  ALU result, or the byte address when in_isLoad=1.
in_isLoad  in  1  instruction is a load.
in_funct3  in  3  load type: LB, LH, LW, LBU or LHU.
rsp_valid  in  1  data-memory response valid, single-cycle.
rsp_data  in  XLEN  word-aligned read data.
wen  out  1  register-file write enable, single-cycle pulse.
rd  out  REG_AW  register-file write address.
dIn  out  XLEN  register-file write data.
ld_fault  out  1  pulse for a misaligned load or an illegal funct3.

Behaviour:
- Reset (async, rstn=0): state=IDLE; wen=0, rd=0, dIn=0, ld_fault=0. Any pending load is discarded.
- Handshake: a transfer occurs when in_valid & in_ready.
- In IDLE, in_ready=1.
- ALU transfer (in_isLoad=0): on the next edge, register rd=in_rd and dIn=in_result. Assert wen=(in_rd!=0) for one cycle. Latency is 1 cycle; throughput is 1 per cycle.
- Load transfer (in_isLoad=1):
  - Capture rd, funct3 and off=in_result[1:0].
  - Move to WAIT; in_ready=0.
- WAIT with rsp_valid=1:
  - Extract the data via ld_align.
  - On the next edge, drive rd/dIn and return to IDLE.
  - wen=1 for one cycle unless rd==0 or a fault occurred.
  - Minimum load occupancy is 2 cycles: accept cycle, then response cycle.
- rsp_valid in IDLE is ignored; no state change.
- rsp_valid arriving in the same cycle as a load is accepted belongs to an earlier request and is ignored.
- Alignment (byte lane = off*8):
  - LB: sign-extend the selected byte.
  - LBU: zero-extend the selected byte.
  - LH/LHU: sign/zero-extend the halfword at off[1]*16; requires off[0]=0.
  - LW: requires off=0.
- Fault: a misaligned access or funct3 in {3,6,7} pulses ld_fault for one cycle (same edge wen would have fired). wen stays 0 and the stage returns to IDLE.
- rd=0 (x0): no wen pulse, but the response is still consumed and the stage still returns to IDLE.
- dIn and rd hold their last values when wen=0.
- Reset asserted in WAIT: the stage is in IDLE after release, and a late rsp_valid is ignored.

Optional Feature:
ALPHA_WB_FWD_EN: when defined, adds three outputs for the ID/EX stage to bypass the register file in the same cycle as the write:
- fwd_valid (1) = wen
- fwd_rd (REG_AW) = rd
- fwd_data (XLEN) = dIn

When not defined, these ports are absent and the consumer must stall one cycle on a hazard with the writeback destination.

Decomposition:
- Shared package alpha_pkg:
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5.
  - wb_state_t enum {IDLE, WAIT}.
  - XLEN/REG_AW defaults.
- One sub-module ld_align: purely combinational (rsp_data, funct3, off -> data, fault). It is reused by a future store-data aligner.

Test Plan:
1. ALU write: in_valid=1, in_rd=10, in_result=32'hBABEFACE, in_isLoad=0 -> next cycle wen=1, rd=10, dIn=BABEFACE for exactly one cycle. Back-to-back ALU ops write on consecutive cycles.
2. x0: ALU op with in_rd=0 and in_result=32'h1234 -> wen stays 0, in_ready stays 1.
3. Byte loads: LB with address ...3, rsp_data=32'h80FF1234 -> dIn=32'hFFFFFF80. LBU, same stimulus -> 32'h00000080. in_ready=0 from accept until the response cycle.
4. Halfword loads: LH with address ...2, rsp_data=32'h80017FFF -> dIn=32'hFFFF8001. LHU, same stimulus -> 32'h00008001. LW with address ...0 -> dIn=32'h80017FFF.
5. Faults: LW with address ...1, response arrives -> ld_fault=1 for one cycle, wen=0, in_ready=1 the following cycle. funct3=3 gives the same result.
6. Reset mid-load: load accepted, rstn pulsed low in WAIT, then rsp_valid=1 after release -> no wen, ld_fault=0, in_ready=1, outputs all zero.

Source files
------------

// File: rtl/alpha_pkg.sv
// Shared types and constants for the alpha pipeline writeback path.
// Load funct3 encodings, writeback FSM states and default widths.
package alpha_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/ld_align.sv
// Combinational load aligner: picks the addressed byte/halfword/word out of a
// word-aligned read and sign/zero-extends it; flags misalignment and bad funct3.
module ld_align
    import alpha_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rsp_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rsp_data[7:0];
        case (off)
            2'd0:    byte_sel = rsp_data[7:0];
            2'd1:    byte_sel = rsp_data[15:8];
            2'd2:    byte_sel = rsp_data[23:16];
            default: byte_sel = rsp_data[31:24];
        endcase
        half_sel = off[1] ? rsp_data[31:16] : rsp_data[15:0];
    end

    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB: begin
                data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            end
            F3_LBU: begin
                data = {{(XLEN-8){1'b0}}, byte_sel};
            end
            F3_LH: begin
                data  = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault = off[0];
            end
            F3_LHU: begin
                data  = {{(XLEN-16){1'b0}}, half_sel};
                fault = off[0];
            end
            F3_LW: begin
                data  = rsp_data;
                fault = (off != 2'd0);
            end
            default: begin
                // funct3 3, 6 and 7 are not loads this stage understands
                fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage driving the register-file write port; loads wait for the memory response.
// Optional macro ALPHA_WB_FWD_EN adds same-cycle bypass outputs (fwd_valid/fwd_rd/fwd_data).
module wb_stage
    import alpha_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic              in_isLoad,
    input  logic [2:0]        in_funct3,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_data,
    output logic              wen,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   dIn,
    output logic              ld_fault,
`ifdef ALPHA_WB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
`endif
    output wb_state_t         dbg_state
);

    // Handshake: an instruction transfers on a rising edge where in_valid & in_ready;
    // in_ready depends only on state, never on in_valid. rsp_valid is a one-cycle
    // strobe with no ready; it is consumed only while a load is outstanding.

    wb_state_t         state_q, state_d;
    logic              wen_q, wen_d;
    logic              ld_fault_q, ld_fault_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   dIn_q, dIn_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;

    logic              in_fire;
    logic [XLEN-1:0]   align_data;
    logic              align_fault;

    ld_align #(
        .XLEN(XLEN)
    ) u_ld_align (
        .rsp_data(rsp_data),
        .funct3  (ld_f3_q),
        .off     (ld_off_q),
        .data    (align_data),
        .fault   (align_fault)
    );

    assign in_fire = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        wen_d      = 1'b0;
        ld_fault_d = 1'b0;
        rd_d       = rd_q;
        dIn_d      = dIn_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (in_isLoad) begin
                        ld_rd_d  = in_rd;
                        ld_f3_d  = in_funct3;
                        ld_off_d = in_result[1:0];
                        state_d  = WAIT;
                    end else if (in_rd != '0) begin
                        // rd/dIn only move on a real write so they hold otherwise
                        wen_d = 1'b1;
                        rd_d  = in_rd;
                        dIn_d = in_result;
                    end
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    state_d = IDLE;
                    if (align_fault) begin
                        ld_fault_d = 1'b1;
                    end else if (ld_rd_q != '0) begin
                        wen_d = 1'b1;
                        rd_d  = ld_rd_q;
                        dIn_d = align_data;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            wen_q      <= 1'b0;
            ld_fault_q <= 1'b0;
            rd_q       <= '0;
            dIn_q      <= '0;
            ld_rd_q    <= '0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            ld_fault_q <= ld_fault_d;
            rd_q       <= rd_d;
            dIn_q      <= dIn_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign wen       = wen_q;
    assign rd        = rd_q;
    assign dIn       = dIn_q;
    assign ld_fault  = ld_fault_q;
    assign dbg_state = state_q;

`ifdef ALPHA_WB_FWD_EN
    assign fwd_valid = wen_q;
    assign fwd_rd    = rd_q;
    assign fwd_data  = dIn_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_wb_stage;
    import alpha_pkg::*;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_isLoad;
    logic [2:0]  in_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] dIn;
    logic        ld_fault;
    wb_state_t   dbg_state;
`ifdef ALPHA_WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 0;

    wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rd    (in_rd),
        .in_result(in_result),
        .in_isLoad(in_isLoad),
        .in_funct3(in_funct3),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .wen      (wen),
        .rd       (rd),
        .dIn      (dIn),
        .ld_fault (ld_fault),
`ifdef ALPHA_WB_FWD_EN
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Load result from the access size and signedness, computed by shifting the word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w, output logic flt);
        int          size;
        bit          uns;
        logic [31:0] sh;
        logic [31:0] val;
        size = 0;
        uns  = 0;
        case (f3)
            3'd0: begin size = 1; uns = 0; end
            3'd1: begin size = 2; uns = 0; end
            3'd2: begin size = 4; uns = 0; end
            3'd4: begin size = 1; uns = 1; end
            3'd5: begin size = 2; uns = 1; end
            default: size = 0;
        endcase
        flt = 1'b0;
        if (size == 0 || (int'(off) % size) != 0) begin
            flt = 1'b1;
            return 32'd0;
        end
        sh = w >> (int'(off) * 8);
        if (size == 4) return sh;
        if (size == 1) begin
            val = sh & 32'h0000_00FF;
            if (!uns && sh[7]) val = val | 32'hFFFF_FF00;
        end else begin
            val = sh & 32'h0000_FFFF;
            if (!uns && sh[15]) val = val | 32'hFFFF_0000;
        end
        return val;
    endfunction

    bit          m_busy;
    logic [4:0]  m_ld_rd;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_ld_off;
    logic        m_wen;
    logic        m_fault;
    logic [4:0]  m_rd;
    logic [31:0] m_din;

    always @(posedge clk or negedge rstn) begin
        logic        flt;
        logic [31:0] v;
        if (!rstn) begin
            m_busy  = 0;
            m_wen   = 0;
            m_fault = 0;
            m_rd    = '0;
            m_din   = '0;
        end else begin
            m_wen   = 0;
            m_fault = 0;
            if (m_busy) begin
                if (rsp_valid) begin
                    m_busy = 0;
                    v = model_load(m_ld_f3, m_ld_off, rsp_data, flt);
                    if (flt) m_fault = 1;
                    else if (m_ld_rd != 0) begin
                        m_wen = 1;
                        m_rd  = m_ld_rd;
                        m_din = v;
                    end
                end
            end else if (in_valid) begin
                if (in_isLoad) begin
                    m_busy   = 1;
                    m_ld_rd  = in_rd;
                    m_ld_f3  = in_funct3;
                    m_ld_off = in_result[1:0];
                end else if (in_rd != 0) begin
                    m_wen = 1;
                    m_rd  = in_rd;
                    m_din = in_result;
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_wen", wen, m_wen);
            check("cmp_fault", ld_fault, m_fault);
            check("cmp_ready", in_ready, !m_busy);
            if (m_wen) begin
                check("cmp_rd", rd, m_rd);
                check("cmp_din", dIn, m_din);
            end
`ifdef ALPHA_WB_FWD_EN
            check("cmp_fwd_valid", fwd_valid, m_wen);
            if (m_wen) begin
                check("cmp_fwd_rd", fwd_rd, m_rd);
                check("cmp_fwd_data", fwd_data, m_din);
            end
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle_in();
        in_valid  = 0;
        in_isLoad = 0;
        rsp_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] val, input string tag);
        in_valid  = 1;
        in_isLoad = 0;
        in_rd     = r;
        in_result = val;
        in_funct3 = 3'd0;
        @(posedge clk); #1;
        check({tag, "_wen"}, wen, (r != 0));
        check({tag, "_ready"}, in_ready, 1'b1);
        if (r != 0) begin
            check({tag, "_rd"}, rd, r);
            check({tag, "_din"}, dIn, val);
        end
    endtask

    task automatic do_load(input logic [4:0] r, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input int delay, input bit stale_rsp,
                           input logic [31:0] exp_data, input bit exp_flt, input string tag);
        in_valid  = 1;
        in_isLoad = 1;
        in_rd     = r;
        in_funct3 = f3;
        in_result = addr;
        rsp_valid = stale_rsp;
        rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        in_valid  = 0;
        in_isLoad = 0;
        rsp_valid = 0;
        check({tag, "_ready_wait"}, in_ready, 1'b0);
        check({tag, "_nowen_wait"}, wen, 1'b0);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check({tag, "_ready_hold"}, in_ready, 1'b0);
        end
        rsp_valid = 1;
        rsp_data  = word;
        @(posedge clk); #1;
        rsp_valid = 0;
        check({tag, "_wen"}, wen, (!exp_flt && r != 0));
        check({tag, "_fault"}, ld_fault, exp_flt);
        check({tag, "_ready_after"}, in_ready, 1'b1);
        if (!exp_flt && r != 0) begin
            check({tag, "_rd"}, rd, r);
            check({tag, "_din"}, dIn, exp_data);
        end
        @(posedge clk); #1;
        check({tag, "_wen_pulse"}, wen, 1'b0);
        check({tag, "_fault_pulse"}, ld_fault, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        mflt;
        logic [31:0] mv;
        rstn      = 0;
        in_valid  = 0;
        in_rd     = '0;
        in_result = '0;
        in_isLoad = 0;
        in_funct3 = '0;
        rsp_valid = 0;
        rsp_data  = '0;

        // Model sanity against literal values
        mv = model_load(3'd0, 2'd3, 32'h80FF1234, mflt);
        check("model_lb", mv, 32'hFFFFFF80);
        mv = model_load(3'd5, 2'd2, 32'h80017FFF, mflt);
        check("model_lhu", mv, 32'h00008001);
        mv = model_load(3'd2, 2'd1, 32'h80017FFF, mflt);
        check("model_lw_mis", mflt, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_wen", wen, 1'b0);
        check("rst_rd", rd, 5'd0);
        check("rst_din", dIn, 32'd0);
        check("rst_fault", ld_fault, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_state", dbg_state, IDLE);
        rstn    = 1;
        run_cmp = 1;
        @(posedge clk); #1;

        // 1. ALU write, one-cycle pulse, then back-to-back
        alu(5'd10, 32'hBABEFACE, "alu1");
        idle_in();
        check("alu1_pulse", wen, 1'b0);
        check("alu1_hold_din", dIn, 32'hBABEFACE);
        alu(5'd3, 32'h0000_0001, "b2b_a");
        alu(5'd4, 32'h0000_0002, "b2b_b");
        alu(5'd5, 32'h0000_0003, "b2b_c");
        idle_in();

        // 2. x0 write suppressed
        alu(5'd0, 32'h0000_1234, "x0");
        idle_in();
        check("x0_hold_din", dIn, 32'h0000_0003);

        // rsp_valid while idle is ignored
        rsp_valid = 1;
        rsp_data  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rsp_valid = 0;
        check("idle_rsp_wen", wen, 1'b0);
        check("idle_rsp_ready", in_ready, 1'b1);

        // 3. byte loads
        do_load(5'd7, 3'd0, 32'h0000_1003, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, "lb3");
        do_load(5'd8, 3'd4, 32'h0000_1003, 32'h80FF1234, 0, 0, 32'h00000080, 0, "lbu3");
        do_load(5'd9, 3'd0, 32'h0000_1001, 32'h80FF1234, 2, 1, 32'h00000012, 0, "lb1_late");

        // 4. halfword and word loads
        do_load(5'd11, 3'd1, 32'h0000_2002, 32'h80017FFF, 0, 0, 32'hFFFF8001, 0, "lh2");
        do_load(5'd12, 3'd5, 32'h0000_2002, 32'h80017FFF, 0, 0, 32'h00008001, 0, "lhu2");
        do_load(5'd13, 3'd1, 32'h0000_2000, 32'h80017FFF, 1, 0, 32'h00007FFF, 0, "lh0");
        do_load(5'd14, 3'd2, 32'h0000_2000, 32'h80017FFF, 0, 0, 32'h80017FFF, 0, "lw0");

        // load into x0 consumes the response without writing
        do_load(5'd0, 3'd2, 32'h0000_2000, 32'h1111_2222, 0, 0, 32'h0, 0, "lw_x0");
        check("lw_x0_hold_din", dIn, 32'h80017FFF);

        // 5. faults
        do_load(5'd15, 3'd2, 32'h0000_3001, 32'h80017FFF, 0, 0, 32'h0, 1, "lw_mis");
        do_load(5'd16, 3'd3, 32'h0000_3000, 32'h80017FFF, 0, 0, 32'h0, 1, "f3_bad");
        do_load(5'd17, 3'd1, 32'h0000_3003, 32'h80017FFF, 0, 0, 32'h0, 1, "lh_mis");

        // ALU op straight after a load completes
        alu(5'd20, 32'hCAFE_0001, "post_ld");
        idle_in();

        // 6. reset while a load is outstanding
        in_valid  = 1;
        in_isLoad = 1;
        in_rd     = 5'd21;
        in_funct3 = 3'd2;
        in_result = 32'h0000_4000;
        @(posedge clk); #1;
        in_valid  = 0;
        in_isLoad = 0;
        check("rstw_ready_wait", in_ready, 1'b0);
        check("rstw_state_wait", dbg_state, WAIT);
        #2;
        rstn = 0;
        #1;
        check("rstw_async_ready", in_ready, 1'b1);
        check("rstw_async_din", dIn, 32'd0);
        @(posedge clk); #1;
        rstn = 1;
        rsp_valid = 1;
        rsp_data  = 32'h5555_AAAA;
        @(posedge clk); #1;
        rsp_valid = 0;
        check("rstw_wen", wen, 1'b0);
        check("rstw_fault", ld_fault, 1'b0);
        check("rstw_ready", in_ready, 1'b1);
        check("rstw_rd", rd, 5'd0);
        check("rstw_din", dIn, 32'd0);
        idle_in();

        // stage usable again after reset
        alu(5'd31, 32'h0F0F_0F0F, "post_rst");
        idle_in();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
